// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes (DBG, DM, IF) and the memory-macro port of the arbiter.
// The arbiter connects through the slave modport; requesters and the memory connect through master.
interface mem_port_arbiter_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRSIZE = 12
);
    // debug / program loader
    logic                dbg_req;
    logic                dbg_we;
    logic [ADDRSIZE-1:0] dbg_addr;
    logic [WIDTH-1:0]    dbg_wdata;
    logic                dbg_gnt;
    logic                dbg_rvalid;
    // data access for LD/STR
    logic                dm_req;
    logic                dm_we;
    logic [ADDRSIZE-1:0] dm_addr;
    logic [WIDTH-1:0]    dm_wdata;
    logic                dm_gnt;
    logic                dm_rvalid;
    // instruction fetch (read only)
    logic                if_req;
    logic [ADDRSIZE-1:0] if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    // shared read return and status
    logic [WIDTH-1:0]    rdata;
    logic                busy;
    // memory macro
    logic                mem_en;
    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  if_req, if_addr,
        input  mem_rdata,
        output dbg_gnt, dbg_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid,
        output rdata, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output if_req, if_addr,
        output mem_rdata,
        input  dbg_gnt, dbg_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid,
        input  rdata, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between DBG, DM and IF.
// One transaction in flight: IDLE (arbitrate + capture) -> ISSUE (strobe memory) -> RDATA (reads).
// Build macro MEM_ARB_STARVE_GUARD_EN: IF is forced to win after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned ADDRSIZE     = 12
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RDATA = 2'd2} state_e;
    typedef enum logic [1:0] {OWN_DBG = 2'd0, OWN_DM = 2'd1, OWN_IF = 2'd2} owner_e;

    state_e              r_state;
    state_e              w_state_nxt;
    owner_e              r_owner;
    owner_e              w_win;
    logic                r_we;
    logic [ADDRSIZE-1:0] r_addr;
    logic [WIDTH-1:0]    r_wdata;
    logic [WIDTH-1:0]    r_rdata;
    logic [2:0]          r_gnt;
    logic [2:0]          r_rvalid;
    logic                r_busy;
    logic                r_mem_en;
    logic                r_mem_we;
    logic                w_any_req;
    logic                w_arb;
    logic                w_win_we;
    logic [ADDRSIZE-1:0] w_win_addr;
    logic [WIDTH-1:0]    w_win_wdata;
    logic [2:0]          w_gnt_nxt;
    logic [2:0]          w_rvalid_nxt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_if_force;

    assign w_if_force = bus.if_req && (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Count consecutive IF losses; clear when IF wins or stops asking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (!bus.if_req || w_win == OWN_IF) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
        end
    end
`endif

    // Winner selection, next state and next-cycle grant/valid strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_any_req    = bus.dbg_req | bus.dm_req | bus.if_req;
        w_arb        = 1'b0;
        w_win        = OWN_IF;
        w_win_we     = 1'b0;
        w_win_addr   = bus.if_addr;
        w_win_wdata  = '0;
        w_gnt_nxt    = 3'b000;
        w_rvalid_nxt = 3'b000;

        if (bus.dbg_req) begin
            w_win = OWN_DBG;
        end else if (bus.dm_req) begin
            w_win = OWN_DM;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (w_if_force) begin
            w_win = OWN_IF;
        end
`endif

        case (w_win)
            OWN_DBG: begin
                w_win_we    = bus.dbg_we;
                w_win_addr  = bus.dbg_addr;
                w_win_wdata = bus.dbg_wdata;
            end
            OWN_DM: begin
                w_win_we    = bus.dm_we;
                w_win_addr  = bus.dm_addr;
                w_win_wdata = bus.dm_wdata;
            end
            default: begin
                w_win_we    = 1'b0;
                w_win_addr  = bus.if_addr;
                w_win_wdata = '0;
            end
        endcase

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_arb       = 1'b1;
                    w_state_nxt = S_ISSUE;
                    case (w_win)
                        OWN_DBG: w_gnt_nxt = 3'b001;
                        OWN_DM:  w_gnt_nxt = 3'b010;
                        default: w_gnt_nxt = 3'b100;
                    endcase
                end
            end
            S_ISSUE: w_state_nxt = r_we ? S_IDLE : S_RDATA;
            S_RDATA: begin
                w_state_nxt = S_IDLE;
                case (r_owner)
                    OWN_DBG: w_rvalid_nxt = 3'b001;
                    OWN_DM:  w_rvalid_nxt = 3'b010;
                    default: w_rvalid_nxt = 3'b100;
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning request; frozen until the next arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= OWN_DBG;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_arb) begin
            r_owner <= w_win;
            r_we    <= w_win_we;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
        end
    end

    // Registered handshake, status and memory strobes; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt    <= 3'b000;
            r_rvalid <= 3'b000;
            r_busy   <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_mem_en <= w_arb;
            r_mem_we <= w_arb && w_win_we;
            if (r_state == S_RDATA) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.dbg_gnt    = r_gnt[0];
    assign bus.dm_gnt     = r_gnt[1];
    assign bus.if_gnt     = r_gnt[2];
    assign bus.dbg_rvalid = r_rvalid[0];
    assign bus.dm_rvalid  = r_rvalid[1];
    assign bus.if_rvalid  = r_rvalid[2];
    assign bus.rdata      = r_rdata;
    assign bus.busy       = r_busy;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a grant/read-valid scoreboard and a memory model.
module tb_mem_port_arbiter;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned ADDRSIZE = 12;

    typedef struct {
        int                  owner;   // 0=DBG 1=DM 2=IF
        logic [ADDRSIZE-1:0] addr;
        logic                we;
        logic [WIDTH-1:0]    data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t q_gnt[$];
    exp_t q_rv[$];
    logic [WIDTH-1:0] mem [0:(1<<ADDRSIZE)-1];

    mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) bus ();

    mem_port_arbiter #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    function automatic int owner_of(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    // Monitor: pop and compare whenever a grant or read-valid appears.
    always @(negedge clk) begin
        logic [2:0] g;
        logic [2:0] v;
        exp_t       e;
        g = {bus.if_gnt, bus.dm_gnt, bus.dbg_gnt};
        v = {bus.if_rvalid, bus.dm_rvalid, bus.dbg_rvalid};
        if ($countones(g) > 1 || $countones(v) > 1 || (bus.mem_en != (g != 3'b000))) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobes: gnt=%b rvalid=%b mem_en=%b", g, v, bus.mem_en);
        end else begin
            if (g != 3'b000) begin
                n_cmp++;
                if (q_gnt.size() == 0) begin
                    n_bad++;
                    $display("FAIL gnt: unexpected grant owner=%0d addr=%h", owner_of(g), bus.mem_addr);
                end else begin
                    e = q_gnt.pop_front();
                    if (owner_of(g) != e.owner || bus.mem_addr != e.addr || bus.mem_we != e.we ||
                        (e.we && bus.mem_wdata != e.data) || !bus.busy) begin
                        n_bad++;
                        $display("FAIL gnt: got owner=%0d addr=%h we=%b wdata=%h busy=%b, required owner=%0d addr=%h we=%b wdata=%h busy=1",
                                 owner_of(g), bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.busy,
                                 e.owner, e.addr, e.we, e.data);
                    end
                end
            end
            if (v != 3'b000) begin
                n_cmp++;
                if (q_rv.size() == 0) begin
                    n_bad++;
                    $display("FAIL rvalid: unexpected read-valid owner=%0d rdata=%h", owner_of(v), bus.rdata);
                end else begin
                    e = q_rv.pop_front();
                    if (owner_of(v) != e.owner || bus.rdata != e.data) begin
                        n_bad++;
                        $display("FAIL rvalid: got owner=%0d rdata=%h, required owner=%0d rdata=%h",
                                 owner_of(v), bus.rdata, e.owner, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_gnt(input int owner, input logic [ADDRSIZE-1:0] addr, input logic we,
                            input logic [WIDTH-1:0] data);
        exp_t e;
        e.owner = owner; e.addr = addr; e.we = we; e.data = data;
        q_gnt.push_back(e);
    endtask

    task automatic push_rv(input int owner, input logic [WIDTH-1:0] data);
        exp_t e;
        e.owner = owner; e.addr = '0; e.we = 1'b0; e.data = data;
        q_rv.push_back(e);
    endtask

    function automatic logic gnt_of(input int id);
        case (id)
            0:       return bus.dbg_gnt;
            1:       return bus.dm_gnt;
            default: return bus.if_gnt;
        endcase
    endfunction

    // Present a request, hold it until granted, then drop it and scramble the payload.
    task automatic issue(input int id, input logic we, input logic [ADDRSIZE-1:0] addr,
                         input logic [WIDTH-1:0] wd);
        int t;
        case (id)
            0: begin bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd; end
            1: begin bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wd; end
            default: begin bus.if_req = 1'b1; bus.if_addr = addr; end
        endcase
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!gnt_of(id) && t < 60);
        if (!gnt_of(id)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant timeout: requester %0d got no grant, required a grant", id);
        end
        case (id)
            0: begin bus.dbg_req = 1'b0; bus.dbg_we = ~we; bus.dbg_addr = ~addr; bus.dbg_wdata = ~wd; end
            1: begin bus.dm_req = 1'b0; bus.dm_we = ~we; bus.dm_addr = ~addr; bus.dm_wdata = ~wd; end
            default: begin bus.if_req = 1'b0; bus.if_addr = ~addr; end
        endcase
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((q_gnt.size() != 0 || q_rv.size() != 0 || bus.busy) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (q_gnt.size() != 0 || q_rv.size() != 0 || bus.busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drain: pending gnt=%0d rvalid=%0d busy=%b, required 0 0 0",
                     name, q_gnt.size(), q_rv.size(), bus.busy);
            q_gnt.delete();
            q_rv.delete();
        end
    endtask

    initial begin
        int ng;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < (1 << ADDRSIZE); i++) mem[i] = '0;
        mem[12'h000] = 32'h0000_00A0;
        mem[12'h010] = 32'hDEAD_BEEF;
        bus.mem_rdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.dm_req  = 1'b0; bus.dm_we  = 1'b0; bus.dm_addr  = '0; bus.dm_wdata  = '0;
        bus.if_req  = 1'b0; bus.if_addr = '0;
        rst_n = 1'b0;

        // T1: reset held with every request asserted
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 12'h010; bus.dbg_wdata = 32'h1111_1111;
        bus.dm_req = 1'b1; bus.if_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("reset strobes", 64'({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt, bus.dbg_rvalid,
                   bus.dm_rvalid, bus.if_rvalid, bus.mem_en, bus.mem_we, bus.busy}), 64'd0);
            check("reset buses", 64'({bus.rdata, bus.mem_addr}), 64'd0);
        end
        bus.dbg_req = 1'b0; bus.dm_req = 1'b0; bus.if_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", 64'(bus.busy), 64'd0);

        // T2: instruction fetch read
        push_gnt(2, 12'h010, 1'b0, '0);
        push_rv(2, 32'hDEAD_BEEF);
        issue(2, 1'b0, 12'h010, '0);
        wait_idle("if read");

        // T3: three-way collision; DBG write lands before DM reads it back
        push_gnt(0, 12'h020, 1'b1, 32'h0000_0005);
        push_gnt(1, 12'h020, 1'b0, '0);
        push_gnt(2, 12'h000, 1'b0, '0);
        push_rv(1, 32'h0000_0005);
        push_rv(2, 32'h0000_00A0);
        fork
            issue(0, 1'b1, 12'h020, 32'h0000_0005);
            issue(1, 1'b0, 12'h020, '0);
            issue(2, 1'b0, 12'h000, '0);
        join
        wait_idle("collision");

        // T4: reset lands while the DM read sits in RDATA; no read-valid may follow
        push_gnt(1, 12'h010, 1'b0, '0);
        issue(1, 1'b0, 12'h010, '0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("busy after mid-read reset", 64'(bus.busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rdata after mid-read reset", 64'(bus.rdata), 64'd0);
        wait_idle("mid-read reset");

        // T5: DM hammers writes while IF keeps fetching
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 4; k++) push_gnt(1, 12'h100, 1'b1, 32'h0BAD_F00D);
        push_gnt(2, 12'h000, 1'b0, '0);
        push_rv(2, 32'h0000_00A0);
        push_gnt(1, 12'h100, 1'b1, 32'h0BAD_F00D);
`else
        for (int k = 0; k < 6; k++) push_gnt(1, 12'h100, 1'b1, 32'h0BAD_F00D);
`endif
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 12'h100; bus.dm_wdata = 32'h0BAD_F00D;
        bus.if_req = 1'b1; bus.if_addr = 12'h000;
        ng = 0;
        for (int t = 0; t < 200 && ng < 6; t++) begin
            @(posedge clk); #1;
            if (bus.dbg_gnt || bus.dm_gnt || bus.if_gnt) ng++;
        end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        check("starvation grant count", 64'(ng), 64'd6);
        wait_idle("starvation");

        // T6: DM write to the top address, then IF reads it back
        push_gnt(1, 12'hFFF, 1'b1, 32'h1234_5678);
        issue(1, 1'b1, 12'hFFF, 32'h1234_5678);
        @(posedge clk); #1;
        check("write returns to idle", 64'(bus.busy), 64'd0);
        wait_idle("dm write");
        push_gnt(2, 12'hFFF, 1'b0, '0);
        push_rv(2, 32'h1234_5678);
        issue(2, 1'b0, 12'hFFF, '0);
        wait_idle("read back");

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
